// File: rtl/mine_placer_pkg.sv
// Shared definitions for the mine placer: FSM states, mine marker,
// neighbour offset table and the LFSR step function.
package mine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_CHECK,
        S_PLACE,
        S_NBR,
        S_DONE
    } state_e;

    // All-ones marker; the top slices it down to its cell width.
    localparam logic [31:0] MINE_CODE = 32'hFFFF_FFFF;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Neighbour offsets, two's complement 2-bit, entry k at [k].
    // Row-major starting at (-1,-1):
    // k: 0:(-1,-1) 1:(0,-1) 2:(1,-1) 3:(-1,0) 4:(1,0) 5:(-1,1) 6:(0,1) 7:(1,1)
    localparam logic [7:0][1:0] NBR_DX = {2'b01, 2'b00, 2'b11, 2'b01,
                                          2'b11, 2'b01, 2'b00, 2'b11};
    localparam logic [7:0][1:0] NBR_DY = {2'b01, 2'b01, 2'b01, 2'b00,
                                          2'b00, 2'b11, 2'b11, 2'b11};

    // Galois right-shift step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mine_placer_lfsr16.sv
// 16-bit Galois LFSR with seed load and step enable. A zero seed is
// replaced by 1 so the register can never lock up.
module lfsr16
    import mine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] next_o
);

    logic [15:0] state_q;

    assign next_o = lfsr_step(state_q);

    // Seed load has priority over stepping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= 16'h0001;
        else if (load_i)
            state_q <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
        else if (step_i)
            state_q <= next_o;
    end

endmodule

// File: rtl/mine_placer.sv
// Mine placer: picks pseudo-random cells, writes the mine marker and
// bumps the adjacency count of each in-bounds non-mine neighbour through
// a combinational read / synchronous write board port.
// Optional feature macro: SAFE_START_EN (keeps mines off the 3x3 area
// around safe_x/safe_y).
module mine_placer
    import mine_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int BUS_WIDTH = 8,
    parameter int NUM_MINES = 10,
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          seed,
`ifdef SAFE_START_EN
    input  logic [XW-1:0]        safe_x,
    input  logic [YW-1:0]        safe_y,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [XW-1:0]        rd_x,
    output logic [YW-1:0]        rd_y,
    input  logic [BUS_WIDTH-1:0] rd_value,
    output logic                 wr_en,
    output logic [XW-1:0]        wr_x,
    output logic [YW-1:0]        wr_y,
    output logic [BUS_WIDTH-1:0] wr_value
);

    localparam int CW = $clog2(WIDTH * HEIGHT) + 1;
    localparam logic [BUS_WIDTH-1:0] MINE   = MINE_CODE[BUS_WIDTH-1:0];
    localparam logic [CW-1:0]        NM     = NUM_MINES[CW-1:0];
    localparam logic [XW:0]          W_U    = WIDTH[XW:0];
    localparam logic [YW:0]          H_U    = HEIGHT[YW:0];
    localparam logic signed [XW+1:0] W_S    = WIDTH[XW+1:0];
    localparam logic signed [YW+1:0] H_S    = HEIGHT[YW+1:0];

    state_e        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [2:0]    k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    logic          lfsr_load, lfsr_step_en;
    logic [15:0]   lfsr_next;
    logic          lfsr_unused;

    logic signed [XW+1:0] nx;
    logic signed [YW+1:0] ny;
    logic                 nbr_in;
    logic                 cand_oob;
    logic                 near_safe;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load_i (lfsr_load),
        .seed_i (seed),
        .step_i (lfsr_step_en),
        .next_o (lfsr_next)
    );

    // Only the low coordinate fields are consumed.
    assign lfsr_unused = ^lfsr_next;

    assign cnt_inc  = cnt_q + CW'(1);
    assign cand_oob = ({1'b0, cx_q} >= W_U) || ({1'b0, cy_q} >= H_U);

    // Neighbour coordinate for offset k, widened and signed so edges
    // show up as negative or >= size instead of wrapping.
    assign nx = $signed({2'b00, cx_q}) + $signed({{XW{NBR_DX[k_q][1]}}, NBR_DX[k_q]});
    assign ny = $signed({2'b00, cy_q}) + $signed({{YW{NBR_DY[k_q][1]}}, NBR_DY[k_q]});
    assign nbr_in = !nx[XW+1] && (nx < W_S) && !ny[YW+1] && (ny < H_S);

`ifdef SAFE_START_EN
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic          near_x, near_y;

    assign near_x = (cx_q == sx_q) ||
                    (({1'b0, cx_q} + 1'b1) == {1'b0, sx_q}) ||
                    (({1'b0, sx_q} + 1'b1) == {1'b0, cx_q});
    assign near_y = (cy_q == sy_q) ||
                    (({1'b0, cy_q} + 1'b1) == {1'b0, sy_q}) ||
                    (({1'b0, sy_q} + 1'b1) == {1'b0, cy_q});
    assign near_safe = near_x && near_y;

    // Safe cell is captured together with the seed on an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    // Hold the safe cell except on an accepted start.
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (state_q == S_IDLE && start) begin
            sx_d = safe_x;
            sy_d = safe_y;
        end
    end
`else
    assign near_safe = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and board port drive; all outputs idle at zero.
    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        rd_x         = '0;
        rd_y         = '0;
        wr_en        = 1'b0;
        wr_x         = '0;
        wr_y         = '0;
        wr_value     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    cnt_d     = '0;
                    k_d       = '0;
                    state_d   = S_PICK;
                end
            end
            S_PICK: begin
                lfsr_step_en = 1'b1;
                cx_d         = lfsr_next[XW-1:0];
                cy_d         = lfsr_next[XW+YW-1:XW];
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                rd_x = cx_q;
                rd_y = cy_q;
                if (cand_oob || near_safe || rd_value == MINE)
                    state_d = S_PICK;
                else
                    state_d = S_PLACE;
            end
            S_PLACE: begin
                wr_en    = 1'b1;
                wr_x     = cx_q;
                wr_y     = cy_q;
                wr_value = MINE;
                k_d      = '0;
                state_d  = S_NBR;
            end
            S_NBR: begin
                if (nbr_in) begin
                    rd_x = nx[XW-1:0];
                    rd_y = ny[YW-1:0];
                    if (rd_value != MINE) begin
                        wr_en    = 1'b1;
                        wr_x     = nx[XW-1:0];
                        wr_y     = ny[YW-1:0];
                        wr_value = rd_value + BUS_WIDTH'(1);
                    end
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == NM) ? S_DONE : S_PICK;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer: one single-mine instance driven with
// hand-computed write sequences, one nearly-full instance checked against
// a board model after completion.
module tb_mine_placer;

`ifdef SAFE_START_EN
    localparam int NM_FULL = 55;
`else
    localparam int NM_FULL = 63;
`endif

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] v;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 1'b0, start2 = 1'b0;
    logic [15:0] seed1 = 16'h0, seed2 = 16'h0;
    logic        busy1, done1, wen1, busy2, done2, wen2;
    logic [2:0]  rdx1, rdy1, wrx1, wry1, rdx2, rdy2, wrx2, wry2;
    logic [7:0]  rdv1, wrv1, rdv2, wrv2;
    logic [2:0]  sx = 3'd7, sy = 3'd7;

    logic [7:0]  b1 [64];
    logic [7:0]  b2 [64];
    logic        clr = 1'b0, pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;

    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   start_cyc = 0, wr_cnt = 0;
    logic chk_en = 1'b0;
    wr_t  exp_wr[$];
    int   exp_lat[$];

    mine_placer #(.WIDTH(8), .HEIGHT(8), .BUS_WIDTH(8), .NUM_MINES(1)) u_one (
        .clk(clk), .reset(reset), .start(start1), .seed(seed1),
`ifdef SAFE_START_EN
        .safe_x(sx), .safe_y(sy),
`endif
        .busy(busy1), .done(done1), .rd_x(rdx1), .rd_y(rdy1), .rd_value(rdv1),
        .wr_en(wen1), .wr_x(wrx1), .wr_y(wry1), .wr_value(wrv1)
    );

    mine_placer #(.WIDTH(8), .HEIGHT(8), .BUS_WIDTH(8), .NUM_MINES(NM_FULL)) u_full (
        .clk(clk), .reset(reset), .start(start2), .seed(seed2),
`ifdef SAFE_START_EN
        .safe_x(sx), .safe_y(sy),
`endif
        .busy(busy2), .done(done2), .rd_x(rdx2), .rd_y(rdy2), .rd_value(rdv2),
        .wr_en(wen2), .wr_x(wrx2), .wr_y(wry2), .wr_value(wrv2)
    );

    // Board models: combinational read, write on rising edge.
    assign rdv1 = b1[{rdy1, rdx1}];
    assign rdv2 = b2[{rdy2, rdx2}];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            for (int i = 0; i < 64; i++) begin
                b1[i] <= 8'h00;
                b2[i] <= 8'h00;
            end
        end else begin
            if (pre_en) b1[pre_idx] <= 8'hFF;
            if (wen1)   b1[{wry1, wrx1}] <= wrv1;
            if (wen2)   b2[{wry2, wrx2}] <= wrv2;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expected write for every strobe and an expected
    // latency for every done pulse of the single-mine instance.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset && chk_en) begin
                if (wen1) begin
                    wr_cnt++;
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", {wrx1, wry1, wrv1}, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_xyv", {wrx1, wry1, wrv1}, e);
                    end
                end
                if (done1 && exp_lat.size() != 0)
                    check("done_latency", cyc - start_cyc, exp_lat.pop_front());
            end
        end
    end

    task automatic push_wr(input int x, input int y, input int v);
        wr_t e;
        e.x = x[2:0];
        e.y = y[2:0];
        e.v = v[7:0];
        exp_wr.push_back(e);
    endtask

    task automatic clear_boards();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic pulse1(input logic [15:0] s, input bit rec);
        @(negedge clk);
        seed1 = s; start1 = 1'b1;
        if (rec) start_cyc = cyc;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int bound);
        int n;
        n = 0;
        while (((which == 1) ? done1 : done2) !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", (which == 1) ? done1 : done2, 1);
    endtask

    // Expected writes for a single mine at (0,0) on an empty board.
    task automatic push_corner();
        push_wr(0, 0, 8'hFF);
        push_wr(1, 0, 1);
        push_wr(0, 1, 1);
        push_wr(1, 1, 1);
        exp_lat.push_back(12);
    endtask

    initial begin
        int w0, mines, bad, n, nxx, nyy;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_wen", wen1, 0);
        check("rst_addr", {rdx1, rdy1, wrx1, wry1, wrv1}, 0);
        check("rst_busy_full", busy2, 0);
        reset = 1'b1;
        clear_boards();

        // Reset mid-run
        pulse1(16'h1234, 0);
        repeat (5) @(negedge clk);
        check("midrun_busy", busy1, 1);
        reset = 1'b0;
        #1;
        check("midrun_rst_wen", wen1, 0);
        check("midrun_rst_busy", busy1, 0);
        @(negedge clk);
        check("midrun_rst_busy2", busy1, 0);
        check("midrun_rst_done", done1, 0);
        reset = 1'b1;
        clear_boards();
        chk_en = 1'b1;

        // Single mine, seed 1 -> (0,0)
        push_corner();
        w0 = wr_cnt;
        pulse1(16'h0001, 1);
        check("start_accepted", busy1, 1);
        wait_done(1, 200);
        @(negedge clk);
        check("busy_after_done", busy1, 0);
        check("corner_wr_count", wr_cnt - w0, 4);
        check("corner_queue_empty", exp_wr.size(), 0);
        check("corner_b00", b1[0], 8'hFF);
        check("corner_b10", b1[1], 1);
        check("corner_b01", b1[8], 1);
        check("corner_b11", b1[9], 1);
        check("corner_b20", b1[2], 0);

        // Preloaded (0,0): five rejections, mine lands on (0,4)
        clear_boards();
        @(negedge clk); pre_en = 1'b1; pre_idx = 6'd0;
        @(negedge clk); pre_en = 1'b0;
        push_wr(0, 4, 8'hFF);
        push_wr(0, 3, 1);
        push_wr(1, 3, 1);
        push_wr(1, 4, 1);
        push_wr(0, 5, 1);
        push_wr(1, 5, 1);
        exp_lat.push_back(22);
        w0 = wr_cnt;
        pulse1(16'h0001, 1);
        wait_done(1, 200);
        @(negedge clk);
        check("retry_wr_count", wr_cnt - w0, 6);
        check("retry_b00_kept", b1[0], 8'hFF);
        check("retry_b04", b1[32], 8'hFF);
        check("retry_queue_empty", exp_wr.size(), 0);

        // start while busy with another seed is ignored
        clear_boards();
        push_corner();
        w0 = wr_cnt;
        pulse1(16'h0001, 1);
        @(negedge clk);
        pulse1(16'h5A5A, 0);
        wait_done(1, 200);
        @(negedge clk);
        check("busy_start_wr_count", wr_cnt - w0, 4);
        check("busy_start_queue_empty", exp_wr.size(), 0);
        check("busy_start_b00", b1[0], 8'hFF);

`ifdef SAFE_START_EN
        // Safe area around (0,0) never receives a mine
        clear_boards();
        chk_en = 1'b0;
        sx = 3'd0; sy = 3'd0;
        pulse1(16'h0001, 0);
        wait_done(1, 2000);
        @(negedge clk);
        check("safe_b00", b1[0], 0);
        check("safe_b10", (b1[1] == 8'hFF) ? 1 : 0, 0);
        check("safe_b01", (b1[8] == 8'hFF) ? 1 : 0, 0);
        check("safe_b11", (b1[9] == 8'hFF) ? 1 : 0, 0);
        sx = 3'd7; sy = 3'd7;
        chk_en = 1'b1;
`endif

        // Nearly full board: mine count and every neighbour count
        clear_boards();
        @(negedge clk);
        seed2 = 16'hACE1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(2, 60000);
        @(negedge clk);
        mines = 0;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (b2[i] == 8'hFF) mines++;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (b2[y*8+x] != 8'hFF) begin
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            nxx = x + dx;
                            nyy = y + dy;
                            if ((dx != 0 || dy != 0) && nxx >= 0 && nxx < 8 &&
                                nyy >= 0 && nyy < 8 && b2[nyy*8+nxx] == 8'hFF)
                                n++;
                        end
                    end
                    if (int'(b2[y*8+x]) != n) bad++;
                end
            end
        end
        check("full_mine_count", mines, NM_FULL);
        check("full_nbr_counts", bad, 0);
`ifdef SAFE_START_EN
        check("full_safe_area", ((b2[54] == 8'hFF) || (b2[55] == 8'hFF) ||
                                 (b2[62] == 8'hFF) || (b2[63] == 8'hFF)) ? 1 : 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
